// File: rtl/sd_spi_pkg.sv
// Shared types and widths for the SD-card SPI initiator.
package sd_spi_pkg;

    localparam int DIV_W = 8;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        OP_XFER      = 2'd0,
        OP_INIT      = 2'd1,
        OP_SET_CS    = 2'd2,
        OP_SET_SPEED = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Loadable down-counter that sets the length of each SCK half-period.
module spi_clk_div
    import sd_spi_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = div_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 initiator for an SD card: byte transfers, chip-select and speed
// control, and the power-up clock burst, all through a single command port.
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter logic [DIV_W-1:0] CLK_DIV_SLOW = 8'd63,
    parameter logic [DIV_W-1:0] CLK_DIV_FAST = 8'd1,
    parameter logic [CNT_W-1:0] INIT_CLOCKS  = 8'd80
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       fast,
    output logic       sd_cs,
    output logic       sd_sck,
    output logic       sd_mosi,
    input  logic       sd_miso,
    output logic       drive_led
);

    state_e           state_q, state_d;
    logic             sck_q, sck_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic             fast_q, fast_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             init_q, init_d;
    logic [CNT_W-1:0] limit;
    logic             accept;
    logic             load;
    logic             tick;

    spi_clk_div u_div (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load_i  (load),
        .div_i   (div_d),
        .tick_o  (tick)
    );

    // Ready is held off for the rx_valid cycle so the requester sees the byte first.
    assign cmd_ready = !reset && (state_q == IDLE) && !rx_valid_q;
    assign accept    = cmd_valid && cmd_ready;
    assign limit     = init_q ? INIT_CLOCKS : CNT_W'(8);

    always_comb begin
        state_d    = state_q;
        sck_d      = sck_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        fast_d     = fast_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bitcnt_d   = bitcnt_q;
        div_d      = div_q;
        init_d     = init_q;
        load       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (op_e'(cmd_op))
                        OP_XFER: begin
                            tx_d     = cmd_data;
                            mosi_d   = cmd_data[7];
                            bitcnt_d = '0;
                            init_d   = 1'b0;
                            div_d    = fast_q ? CLK_DIV_FAST : CLK_DIV_SLOW;
                            load     = 1'b1;
                            state_d  = LOW;
                        end
                        OP_INIT: begin
                            cs_d     = 1'b1;
                            mosi_d   = 1'b1;
                            bitcnt_d = '0;
                            init_d   = 1'b1;
                            div_d    = CLK_DIV_SLOW;
                            load     = 1'b1;
                            state_d  = LOW;
                        end
                        OP_SET_CS:    cs_d   = cmd_data[0];
                        OP_SET_SPEED: fast_d = cmd_data[0];
                        default: ;
                    endcase
                end
            end
            LOW: begin
                if (tick) begin
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[6:0], sd_miso};
                    load    = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    sck_d    = 1'b0;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_d == limit) begin
                        state_d = init_q ? IDLE : DONE;
                    end else begin
                        // MOSI changes on the falling edge, a full half-period before the next rise.
                        if (!init_q) begin
                            mosi_d = tx_q[6];
                            tx_d   = {tx_q[6:0], 1'b1};
                        end
                        load    = 1'b1;
                        state_d = LOW;
                    end
                end
            end
            DONE: begin
                rx_valid_d = 1'b1;
                rx_data_d  = rx_q;
                mosi_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b1;
            fast_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            fast_q     <= fast_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        tx_q     <= tx_d;
        rx_q     <= rx_d;
        bitcnt_q <= bitcnt_d;
        div_q    <= div_d;
        init_q   <= init_d;
    end

    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign busy      = ~cmd_ready;
    assign fast      = fast_q;
    assign sd_cs     = cs_q;
    assign sd_sck    = sck_q;
    assign sd_mosi   = mosi_q;
    assign drive_led = ~cs_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master with a scoreboard on received bytes and a
// simple mode-0 card model on MISO.
module tb_sd_spi_master;
    import sd_spi_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       fast;
    logic       sd_cs;
    logic       sd_sck;
    logic       sd_mosi;
    logic       sd_miso;
    logic       drive_led;

    sd_spi_master dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .busy      (busy),
        .fast      (fast),
        .sd_cs     (sd_cs),
        .sd_sck    (sd_sck),
        .sd_mosi   (sd_mosi),
        .sd_miso   (sd_miso),
        .drive_led (drive_led)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         lat;
        int         acc;
    } exp_t;
    exp_t sb[$];

    // Card model: shifts its byte out MSB first, advancing on each SCK fall.
    logic [7:0] slave_byte = 8'h00;
    int slave_base = 0;
    int slave_falls = 0;
    always @(negedge sd_sck) slave_falls <= slave_falls + 1;
    assign sd_miso = slave_byte[3'(7 - (slave_falls - slave_base))];

    logic [7:0] mosi_cap = 8'h00;
    int rises = 0;
    int bad_rises = 0;
    always @(posedge sd_sck) begin
        mosi_cap <= {mosi_cap[6:0], sd_mosi};
        rises    <= rises + 1;
        if (sd_cs !== 1'b1 || sd_mosi !== 1'b1) bad_rises <= bad_rises + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    int last_rx_cyc = -1;
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            if (rx_valid === 1'b1) begin
                exp_t e;
                last_rx_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rx_valid: got rx_data %0h expected no rx_valid", rx_data);
                end else begin
                    e = sb.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.data));
                    check("rx_latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] d, output int acc);
        int n;
        n = 0;
        @(negedge clk_sys);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        while (cmd_ready !== 1'b1 && n < 20000) begin
            @(negedge clk_sys);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            fail_now("send_accept");
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk_sys);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic send_xfer(input logic [7:0] tx, input logic [7:0] rx, input int lat, output int acc);
        slave_byte = rx;
        slave_base = slave_falls;
        send(OP_XFER, tx, acc);
        if (acc >= 0) sb.push_back('{data: rx, lat: lat, acc: acc});
    endtask

    task automatic wait_ready(input string name, input int max_cycles);
        int n;
        n = 0;
        @(negedge clk_sys);
        while (cmd_ready !== 1'b1 && n < max_cycles) begin
            @(negedge clk_sys);
            n++;
        end
        if (cmd_ready !== 1'b1) fail_now(name);
    endtask

    task automatic wait_rx(input string name, input int max_cycles);
        int n;
        n = 0;
        @(negedge clk_sys);
        while (rx_valid !== 1'b1 && n < max_cycles) begin
            @(negedge clk_sys);
            n++;
        end
        if (rx_valid !== 1'b1) fail_now(name);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, r0, b0, n, cs_bad, len;

        // Reset held for three cycles
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_sd_cs", 32'(sd_cs), 1);
        check("rst_sd_sck", 32'(sd_sck), 0);
        check("rst_sd_mosi", 32'(sd_mosi), 1);
        check("rst_fast", 32'(fast), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_drive_led", 32'(drive_led), 0);
        @(negedge clk_sys);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(cmd_ready), 1);

        // Slow transfer
        send(OP_SET_CS, 8'h00, acc);
        check("set_cs_low", 32'(sd_cs), 0);
        check("set_cs_led", 32'(drive_led), 1);
        check("set_cs_ready", 32'(cmd_ready), 1);
        r0 = rises;
        send_xfer(8'hA5, 8'h3C, 1025, acc);
        wait_ready("slow_xfer_done", 1200);
        check("slow_mosi_bits", 32'(mosi_cap), 32'hA5);
        check("slow_sck_rises", rises - r0, 8);
        check("slow_rx_data_held", 32'(rx_data), 32'h3C);
        check("slow_led", 32'(drive_led), 1);
        check("slow_cs_kept", 32'(sd_cs), 0);

        // Fast back-to-back
        send(OP_SET_SPEED, 8'h01, acc);
        check("set_speed_fast", 32'(fast), 1);
        send_xfer(8'hFF, 8'h81, 33, acc);
        wait_rx("fast_first_rx", 100);
        send_xfer(8'h00, 8'h7E, 33, acc2);
        check("b2b_accept_gap", acc2 - last_rx_cyc, 2);
        wait_ready("fast_second_done", 100);
        check("fast_mosi_bits", 32'(mosi_cap), 32'h00);
        check("fast_rx_data", 32'(rx_data), 32'h7E);

        // INIT burst: always slow, chip-select forced high
        r0 = rises;
        b0 = bad_rises;
        cs_bad = 0;
        n = 0;
        send(OP_INIT, 8'h00, acc);
        while (n < 11000) begin
            @(negedge clk_sys);
            if (cmd_ready === 1'b1) break;
            if (sd_cs !== 1'b1 || sd_mosi !== 1'b1) cs_bad++;
            n++;
        end
        if (cmd_ready !== 1'b1) fail_now("init_done");
        len = cyc - acc;
        checks++;
        if (len < 10240 || len > 10241) begin
            errors++;
            $display("FAIL init_length: got %0d cycles expected 10240..10241", len);
        end
        check("init_sck_rises", rises - r0, 80);
        check("init_cs_mosi_at_rise", bad_rises - b0, 0);
        check("init_cs_mosi_steady", cs_bad, 0);
        check("init_cs_after", 32'(sd_cs), 1);

        // Busy ignore
        send(OP_SET_CS, 8'h00, acc);
        send_xfer(8'h0F, 8'h5A, 33, acc);
        repeat (5) @(negedge clk_sys);
        check("busy_during_xfer", 32'(cmd_ready), 0);
        cmd_valid = 1'b1;
        cmd_op    = OP_SET_CS;
        cmd_data  = 8'h01;
        @(negedge clk_sys);
        cmd_valid = 1'b0;
        wait_ready("busy_xfer_done", 100);
        check("busy_ignore_cs", 32'(sd_cs), 0);
        check("busy_ignore_rx", 32'(rx_data), 32'h5A);

        // Reset in the middle of a transfer
        r0 = rises;
        send_xfer(8'hA5, 8'h96, 33, acc);
        n = 0;
        while (rises - r0 < 3 && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        if (rises - r0 < 3) fail_now("mid_third_rise");
        reset = 1'b1;
        sb.delete();
        @(posedge clk_sys);
        #1;
        check("mid_rst_sck", 32'(sd_sck), 0);
        check("mid_rst_cs", 32'(sd_cs), 1);
        check("mid_rst_mosi", 32'(sd_mosi), 1);
        check("mid_rst_rx_valid", 32'(rx_valid), 0);
        check("mid_rst_fast", 32'(fast), 0);
        check("mid_rst_ready", 32'(cmd_ready), 0);
        @(negedge clk_sys);
        reset = 1'b0;
        #1;
        check("mid_ready_after", 32'(cmd_ready), 1);
        repeat (40) @(negedge clk_sys);
        send(OP_SET_CS, 8'h00, acc);
        send_xfer(8'h55, 8'hC3, 1025, acc);
        wait_ready("fresh_xfer_done", 1200);
        check("fresh_mosi_bits", 32'(mosi_cap), 32'h55);
        check("fresh_rx_data", 32'(rx_data), 32'hC3);

        repeat (2) @(negedge clk_sys);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
